shift_seq8: RTL and testbench

//  Multi-cycle shift sequencer for the 8-bit shifter datapath.
//  - Accepts one 8-bit operand, an opcode and a 0..7 shift amount.
//  - Drives a 2-bit-shamt step shifter repeatedly, shifting by at most 3 bits per cycle.
//  - Returns the result with a one-cycle done pulse.
//  - Sits directly upstream of the 8-bit shifter stage and feeds it operand/shamt each cycle.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shifter8_step.sv | 55 +++++
 rtl/shift_seq8.sv | 87 ++++++++
 tb/tb_shift_seq8.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle 8-bit shift sequencer and its step shifter.
// Latency: n/a (declarations only). Backpressure: n/a.
package shift_pkg;

    localparam logic [1:0] OP_LSL  = 2'b00;
    localparam logic [1:0] OP_LSR  = 2'b01;
    localparam logic [1:0] OP_ASR  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam int STEP_MAX = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Largest step the 2-bit step shifter can take toward the remaining amount.
    function automatic logic [1:0] clamp_step(input logic [2:0] rem);
        return (rem > 3'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];
    endfunction

endpackage

// File: rtl/shifter8_step.sv
// Single-step 8-bit shifter: LSL/LSR/ASR by 0..3 bits, pass-through for op 11.
// Latency: combinational. Backpressure: none.
// Flow control: none; output follows inputs.
module shifter8_step
    import shift_pkg::*;
(
    input  logic [7:0] d,
    input  logic [1:0] op,
    input  logic [1:0] sh,
    output logic [7:0] q
);

    logic [7:0] lsl_dat;
    logic [7:0] lsr_dat;
    logic [7:0] asr_dat;

    always_comb begin
        lsl_dat = d;
        lsr_dat = d;
        asr_dat = d;
        case (sh)
            2'd1: begin
                lsl_dat = {d[6:0], 1'b0};
                lsr_dat = {1'b0, d[7:1]};
                asr_dat = {d[7], d[7:1]};
            end
            2'd2: begin
                lsl_dat = {d[5:0], 2'b00};
                lsr_dat = {2'b00, d[7:2]};
                asr_dat = {{2{d[7]}}, d[7:2]};
            end
            2'd3: begin
                lsl_dat = {d[4:0], 3'b000};
                lsr_dat = {3'b000, d[7:3]};
                asr_dat = {{3{d[7]}}, d[7:3]};
            end
            default: begin
                lsl_dat = d;
                lsr_dat = d;
                asr_dat = d;
            end
        endcase
    end

    always_comb begin
        q = d;
        case (op)
            OP_LSL:  q = lsl_dat;
            OP_LSR:  q = lsr_dat;
            OP_ASR:  q = asr_dat;
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle shift sequencer: applies a 0..7 bit shift as up to three 0..3 bit steps.
// Latency: max(1, ceil(shamt/3)) edges from start to done (1 for pass-through).
// Backpressure: start is ignored while busy; no queueing.
module shift_seq8
    import shift_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  d_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  d_out,
    output logic               busy,
    output logic               done
);

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] rem, rem_nxt;
    logic [1:0]         op_q, op_nxt;
    logic [DATA_W-1:0]  d_nxt;
    logic [DATA_W-1:0]  step_dat;
    logic [1:0]         step;
    logic [SHAMT_W-1:0] rem_after;

    assign step      = clamp_step(rem);
    assign rem_after = rem - SHAMT_W'(step);

    shifter8_step u_step (
        .d  (d_out),
        .op (op_q),
        .sh (step),
        .q  (step_dat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            rem   <= '0;
            op_q  <= '0;
            d_out <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            op_q  <= op_nxt;
            d_out <= d_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        op_nxt    = op_q;
        d_nxt     = d_out;
        case (state)
            S_IDLE: begin
                if (start) begin
                    d_nxt     = d_in;
                    op_nxt    = op;
                    // Pass-through needs no steps; a zero count sends it straight to DONE.
                    rem_nxt   = (op == OP_PASS) ? '0 : shamt;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                d_nxt   = step_dat;
                rem_nxt = rem_after;
                if (rem_after == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_seq8.sv
// Directed bench for shift_seq8: hand-computed results, latencies and handshake checks.
module tb_shift_seq8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] d_in = 8'h00;
    logic [2:0] shamt = 3'd0;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    shift_seq8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .d_in    (d_in),
        .shamt   (shamt),
        .d_out   (d_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one request and follow it to completion, checking result, latency and handshakes.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] d,
                          input logic [2:0] s, input logic [7:0] exp_d, input int exp_lat);
        int lat;
        int busy_c;
        int done_c;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        d_in  = d;
        shamt = s;
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        busy_c = busy ? 1 : 0;
        done_c = done ? 1 : 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (busy) busy_c++;
            if (done) done_c++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_dout"}, d_out, exp_d);
        @(negedge clk);
        check({tag, "_idle"}, {busy, done}, 2'b00);
        check({tag, "_busy_cycles"}, busy_c, exp_lat + 1);
        check({tag, "_done_cnt"}, done_c, 1);
        check({tag, "_dout_hold"}, d_out, exp_d);
    endtask

    initial begin
        int done_c;

        // 1. reset state
        #1;
        check("reset_dout", d_out, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("asr_aa_7", 2'b10, 8'hAA, 3'd7, 8'hFF, 3);

        // 2..4. main function, boundary amounts, pass-through
        run_op("lsr_aa_4", 2'b01, 8'hAA, 3'd4, 8'h0A, 2);
        run_op("lsl_18_3", 2'b00, 8'h18, 3'd3, 8'hC0, 1);
        run_op("asr_40_5", 2'b10, 8'h40, 3'd5, 8'h02, 2);
        run_op("asr_96_0", 2'b10, 8'h96, 3'd0, 8'h96, 1);
        run_op("pass_5a_7", 2'b11, 8'h5A, 3'd7, 8'h5A, 1);
        run_op("lsl_81_7", 2'b00, 8'h81, 3'd7, 8'h80, 3);
        run_op("lsr_f0_6", 2'b01, 8'hF0, 3'd6, 8'h03, 2);

        // 5. start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        d_in  = 8'h80;
        shamt = 3'd7;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        op    = 2'b00;
        d_in  = 8'h01;
        shamt = 3'd1;
        @(negedge clk);
        start  = 1'b0;
        done_c = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_c++;
            @(negedge clk);
        end
        check("ignore_done_cnt", done_c, 1);
        check("ignore_dout", d_out, 8'hFF);
        check("ignore_idle", busy, 1'b0);

        // 6. reset mid-operation aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        d_in  = 8'hFF;
        shamt = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_mid_dout", d_out, 8'h1F);
        reset_n = 1'b0;
        #1;
        check("abort_dout", d_out, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        done_c  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) done_c++;
        end
        check("abort_no_done", done_c, 0);

        run_op("lsr_ff_7", 2'b01, 8'hFF, 3'd7, 8'h01, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
